// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer.
// Detects flags and aborts on the raw Rx bit stream, removes stuffed zeros and
// assembles bytes LSB-first. Each completed byte is held back by one byte time,
// so bits belonging to the closing flag never reach the data stream. Frame
// status (EoF, error, overflow, size) is reported to the Rx buffer stage.
module hdlc_rx_deframer #(
    parameter int MAX_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_EoF,
    output logic       Rx_FrameError,
    output logic       Rx_Overflow,
    output logic [7:0] Rx_FrameSize
);

    typedef enum logic [1:0] {
        HUNT,
        OPEN,
        FRAME
    } stateType;

    localparam logic [7:0] MaxSize = 8'(MAX_BYTES);

    stateType   state;
    logic [7:0] hist;        // raw bit history, newest bit in [7]
    logic [2:0] onesCnt;     // consecutive ones, saturating at 7
    logic [2:0] bitCnt;      // destuffed bits in the byte being assembled
    logic [7:0] acc;         // byte under assembly
    logic [7:0] pendByte;    // last completed byte, not yet emitted
    logic       pendValid;

    logic [7:0] histNext;
    logic [7:0] accNext;
    logic       flagSeen;
    logic       abortSeen;
    logic       stuffBit;
    logic       aligned;
    logic       sizeFull;
    logic [8:0] closeCount;

    // Ones run length after taking in one more raw bit.
    function automatic logic [2:0] onesStep(input logic [2:0] count, input logic bitIn);
        if (!bitIn) begin
            return 3'd0;
        end
        if (count == 3'd7) begin
            return 3'd7;
        end
        return count + 3'd1;
    endfunction

    // Frame byte count after one more emission, held at the frame limit.
    function automatic logic [7:0] sizeStep(input logic [7:0] size);
        if (size >= MaxSize) begin
            return MaxSize;
        end
        return size + 8'd1;
    endfunction

    // Decode the bit currently on the line against the stored history.
    always_comb begin
        histNext   = {Rx, hist[7:1]};
        accNext    = {Rx, acc[7:1]};
        flagSeen   = (histNext == 8'h7E);
        // The seventh consecutive one; a longer run of ones signals only once.
        abortSeen  = Rx && (onesCnt == 3'd6);
        // A zero after exactly five ones was inserted by the transmitter.
        stuffBit   = !Rx && (onesCnt == 3'd5);
        // Seven destuffed bits since the last boundary: the flag's final bit
        // lands exactly where a byte would have completed.
        aligned    = (bitCnt == 3'd7);
        sizeFull   = (Rx_FrameSize >= MaxSize);
        // Bytes in the frame once the pending byte is emitted at close.
        closeCount = {1'b0, Rx_FrameSize} + ((aligned && !sizeFull) ? 9'd1 : 9'd0);
    end

    // Frame state machine, byte assembly and registered Rx_* outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state          <= HUNT;
            hist           <= 8'h00;
            onesCnt        <= 3'd0;
            bitCnt         <= 3'd0;
            acc            <= 8'h00;
            pendByte       <= 8'h00;
            pendValid      <= 1'b0;
            Rx_Data        <= 8'h00;
            Rx_NewByte     <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_ValidFrame  <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;
            Rx_Overflow    <= 1'b0;
            Rx_FrameSize   <= 8'h00;
        end else begin
            // Pulses last exactly one clock, whether or not a bit arrives.
            Rx_NewByte     <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameError  <= 1'b0;

            if (RxEN) begin
                hist    <= histNext;
                onesCnt <= onesStep(onesCnt, Rx);

                if (abortSeen) begin
                    // Abort beats everything: the frame is dropped silently.
                    Rx_AbortDetect <= 1'b1;
                    if (state != HUNT) begin
                        state         <= HUNT;
                        Rx_ValidFrame <= 1'b0;
                        pendValid     <= 1'b0;
                    end
                end else if (flagSeen) begin
                    // Any flag realigns byte assembly; a partial acc is dropped.
                    Rx_FlagDetect <= 1'b1;
                    Rx_ValidFrame <= 1'b1;
                    bitCnt        <= 3'd0;
                    pendValid     <= 1'b0;
                    state         <= OPEN;
                    if (state == FRAME) begin
                        // Closing flag: status stays visible until the next frame.
                        Rx_EoF <= 1'b1;
                        if (aligned && pendValid) begin
                            if (sizeFull) begin
                                Rx_Overflow <= 1'b1;
                            end else begin
                                Rx_Data      <= pendByte;
                                Rx_NewByte   <= 1'b1;
                                Rx_FrameSize <= sizeStep(Rx_FrameSize);
                            end
                        end
                        Rx_FrameError <= !aligned || (closeCount < 9'd2);
                    end else begin
                        // Opening or idle flag starts a fresh status.
                        Rx_Overflow  <= 1'b0;
                        Rx_FrameSize <= 8'h00;
                    end
                end else if ((state != HUNT) && !stuffBit) begin
                    acc    <= accNext;
                    bitCnt <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        pendByte  <= accNext;
                        pendValid <= 1'b1;
                        if (state == OPEN) begin
                            // First byte of a frame whose opening flag was
                            // shared with the previous frame's close.
                            state        <= FRAME;
                            Rx_Overflow  <= 1'b0;
                            Rx_FrameSize <= 8'h00;
                        end else if (pendValid) begin
                            if (sizeFull) begin
                                Rx_Overflow <= 1'b1;
                            end else begin
                                Rx_Data      <= pendByte;
                                Rx_NewByte   <= 1'b1;
                                Rx_FrameSize <= sizeStep(Rx_FrameSize);
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed testbench for hdlc_rx_deframer (instantiated with MAX_BYTES=4).
module tb_hdlc_rx_deframer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       RxEN;
    logic       Rx;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_Overflow;
    logic [7:0] Rx_FrameSize;

    hdlc_rx_deframer #(.MAX_BYTES(4)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .RxEN          (RxEN),
        .Rx            (Rx),
        .Rx_Data       (Rx_Data),
        .Rx_NewByte    (Rx_NewByte),
        .Rx_FlagDetect (Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ValidFrame (Rx_ValidFrame),
        .Rx_EoF        (Rx_EoF),
        .Rx_FrameError (Rx_FrameError),
        .Rx_Overflow   (Rx_Overflow),
        .Rx_FrameSize  (Rx_FrameSize)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Event log filled on the falling edge, away from the active edge.
    logic [7:0] bytes[$];
    logic       byteAtEof[$];
    int         eofCnt = 0;
    int         abortCnt = 0;
    int         flagCnt = 0;
    logic       lastErr = 1'b0;
    logic       lastOvf = 1'b0;
    logic       eofWithByte = 1'b0;
    logic [7:0] lastSize = 8'h00;

    always @(negedge Clk) begin
        if (Rx_NewByte) begin
            bytes.push_back(Rx_Data);
            byteAtEof.push_back(Rx_EoF);
        end
        if (Rx_EoF) begin
            eofCnt++;
            lastErr     = Rx_FrameError;
            lastOvf     = Rx_Overflow;
            lastSize    = Rx_FrameSize;
            eofWithByte = Rx_NewByte;
        end
        if (Rx_AbortDetect) abortCnt++;
        if (Rx_FlagDetect) flagCnt++;
    end

    bit toggleMode = 1'b0;
    int txOnes = 0;

    task automatic sendBit(input logic b);
        Rx = b;
        RxEN = 1'b1;
        @(posedge Clk); #1;
        if (toggleMode) begin
            RxEN = 1'b0;
            @(posedge Clk); #1;
        end
        txOnes = b ? txOnes + 1 : 0;
    endtask

    task automatic sendRaw(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) sendBit(bits[i]);
    endtask

    task automatic sendFlag();
        sendRaw(16'h007E, 8);
    endtask

    // Transmitter-side stuffing: a zero after every five consecutive ones.
    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            sendBit(v[i]);
            if (txOnes == 5) sendBit(1'b0);
        end
    endtask

    task automatic idle(input int n);
        RxEN = 1'b0;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; RxEN = 1'b0; Rx = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (Rx_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", Rx_Data); end
        checks++; if ({Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 00000", {Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_EoF, Rx_FrameError}); end
        checks++; if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Rx_ValidFrame); end
        checks++; if (Rx_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", Rx_Overflow); end
        checks++; if (Rx_FrameSize !== 8'h00) begin errors++; $display("FAIL reset_size: got %0h expected 0", Rx_FrameSize); end
        @(negedge Clk);
        Rst = 1'b1;
        idle(2);
        checks++; if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", Rx_ValidFrame); end
    endtask

    task automatic test_basic_frame(input bit tog);
        int b0 = bytes.size();
        int e0 = eofCnt;
        int f0 = flagCnt;
        toggleMode = tog;
        sendFlag();
        sendFlag();
        sendByte(8'h12);
        sendByte(8'h34);
        sendFlag();
        idle(3);
        toggleMode = 1'b0;
        checks++; if (bytes.size() - b0 !== 2) begin errors++; $display("FAIL basic%0d_count: got %0d expected 2", tog, bytes.size() - b0); end
        checks++; if (bytes[b0] !== 8'h12) begin errors++; $display("FAIL basic%0d_byte0: got %0h expected 12", tog, bytes[b0]); end
        checks++; if (bytes[b0+1] !== 8'h34) begin errors++; $display("FAIL basic%0d_byte1: got %0h expected 34", tog, bytes[b0+1]); end
        checks++; if ({byteAtEof[b0], byteAtEof[b0+1]} !== 2'b01) begin errors++; $display("FAIL basic%0d_eof_align: got %b expected 01", tog, {byteAtEof[b0], byteAtEof[b0+1]}); end
        checks++; if (eofCnt - e0 !== 1) begin errors++; $display("FAIL basic%0d_eof_count: got %0d expected 1", tog, eofCnt - e0); end
        checks++; if (lastErr !== 1'b0) begin errors++; $display("FAIL basic%0d_err: got %b expected 0", tog, lastErr); end
        checks++; if (lastSize !== 8'd2) begin errors++; $display("FAIL basic%0d_size: got %0d expected 2", tog, lastSize); end
        checks++; if (flagCnt - f0 !== 3) begin errors++; $display("FAIL basic%0d_flags: got %0d expected 3", tog, flagCnt - f0); end
        checks++; if (Rx_ValidFrame !== 1'b1) begin errors++; $display("FAIL basic%0d_valid: got %b expected 1", tog, Rx_ValidFrame); end
        checks++; if (Rx_EoF !== 1'b0) begin errors++; $display("FAIL basic%0d_eof_clear: got %b expected 0", tog, Rx_EoF); end
    endtask

    task automatic test_stuffed();
        int b0 = bytes.size();
        int e0 = eofCnt;
        sendFlag();
        sendRaw(16'h005F, 9);   // 0x3F on the wire: 1,1,1,1,1,0,1,0,0
        sendByte(8'hAA);
        sendFlag();
        idle(2);
        checks++; if (bytes.size() - b0 !== 2) begin errors++; $display("FAIL stuff_count: got %0d expected 2", bytes.size() - b0); end
        checks++; if (bytes[b0] !== 8'h3F) begin errors++; $display("FAIL stuff_byte0: got %0h expected 3f", bytes[b0]); end
        checks++; if (bytes[b0+1] !== 8'hAA) begin errors++; $display("FAIL stuff_byte1: got %0h expected aa", bytes[b0+1]); end
        checks++; if (eofCnt - e0 !== 1 || lastErr !== 1'b0) begin errors++; $display("FAIL stuff_eof: got eof=%0d err=%b expected eof=1 err=0", eofCnt - e0, lastErr); end
    endtask

    task automatic test_misaligned();
        int b0 = bytes.size();
        int e0 = eofCnt;
        sendFlag();
        sendByte(8'h55);
        sendRaw(16'h0000, 11);
        sendFlag();
        idle(2);
        checks++; if (bytes[b0] !== 8'h55) begin errors++; $display("FAIL misalign_byte0: got %0h expected 55", bytes[b0]); end
        checks++; if (eofCnt - e0 !== 1) begin errors++; $display("FAIL misalign_eof: got %0d expected 1", eofCnt - e0); end
        checks++; if (lastErr !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", lastErr); end
        checks++; if (eofWithByte !== 1'b0) begin errors++; $display("FAIL misalign_close_byte: got %b expected 0", eofWithByte); end
    endtask

    task automatic test_short_frame();
        int b0 = bytes.size();
        sendFlag();
        sendByte(8'h12);
        sendFlag();
        idle(2);
        checks++; if (bytes.size() - b0 !== 1 || bytes[b0] !== 8'h12) begin errors++; $display("FAIL short_byte: got n=%0d %0h expected n=1 12", bytes.size() - b0, bytes[b0]); end
        checks++; if (lastErr !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", lastErr); end
        checks++; if (lastSize !== 8'd1) begin errors++; $display("FAIL short_size: got %0d expected 1", lastSize); end
    endtask

    task automatic test_abort();
        int b0 = bytes.size();
        int e0 = eofCnt;
        int a0 = abortCnt;
        int f0;
        sendFlag();
        sendByte(8'h01);
        sendRaw(16'h003F, 6);
        checks++; if (Rx_AbortDetect !== 1'b0) begin errors++; $display("FAIL abort_early: got %b expected 0", Rx_AbortDetect); end
        sendBit(1'b1);
        checks++; if (Rx_AbortDetect !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", Rx_AbortDetect); end
        checks++; if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", Rx_ValidFrame); end
        idle(2);
        f0 = flagCnt;
        sendByte(8'h12);
        sendByte(8'h34);
        idle(2);
        checks++; if (abortCnt - a0 !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", abortCnt - a0); end
        checks++; if (eofCnt - e0 !== 0) begin errors++; $display("FAIL abort_eof: got %0d expected 0", eofCnt - e0); end
        checks++; if (bytes.size() - b0 !== 0) begin errors++; $display("FAIL abort_bytes: got %0d expected 0", bytes.size() - b0); end
        checks++; if (Rx_ValidFrame !== 1'b0 || flagCnt != f0) begin errors++; $display("FAIL abort_hunt: got valid=%b flags=%0d expected valid=0 flags=0", Rx_ValidFrame, flagCnt - f0); end
    endtask

    task automatic test_overflow();
        int b0 = bytes.size();
        int e0 = eofCnt;
        logic [7:0] data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendFlag();
        for (int i = 0; i < 6; i++) sendByte(data[i]);
        sendFlag();
        idle(2);
        checks++; if (bytes.size() - b0 !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", bytes.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bytes[b0+i] !== data[i]) begin errors++; $display("FAIL ovf_byte%0d: got %0h expected %0h", i, bytes[b0+i], data[i]); end
        end
        checks++; if (eofCnt - e0 !== 1) begin errors++; $display("FAIL ovf_eof: got %0d expected 1", eofCnt - e0); end
        checks++; if (lastOvf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", lastOvf); end
        checks++; if (lastSize !== 8'd4) begin errors++; $display("FAIL ovf_size: got %0d expected 4", lastSize); end
        checks++; if (lastErr !== 1'b0 || eofWithByte !== 1'b0) begin errors++; $display("FAIL ovf_close: got err=%b byte=%b expected 0 0", lastErr, eofWithByte); end
        checks++; if (Rx_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", Rx_Overflow); end
        sendFlag();
        idle(2);
        checks++; if (Rx_Overflow !== 1'b0 || Rx_FrameSize !== 8'd0) begin errors++; $display("FAIL ovf_clear: got ovf=%b size=%0d expected 0 0", Rx_Overflow, Rx_FrameSize); end
    endtask

    task automatic test_reset_midframe();
        int b0 = bytes.size();
        int e0 = eofCnt;
        sendFlag();
        sendByte(8'h12);
        sendRaw(16'h0004, 4);
        RxEN = 1'b0;
        checks++; if (Rx_ValidFrame !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", Rx_ValidFrame); end
        Rst = 1'b0;
        #1;
        checks++; if ({Rx_ValidFrame, Rx_NewByte, Rx_EoF, Rx_FlagDetect, Rx_AbortDetect, Rx_FrameError, Rx_Overflow} !== 7'b0 || Rx_Data !== 8'h00 || Rx_FrameSize !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got flags=%b data=%0h size=%0h expected all 0", {Rx_ValidFrame, Rx_NewByte, Rx_EoF, Rx_FlagDetect, Rx_AbortDetect, Rx_FrameError, Rx_Overflow}, Rx_Data, Rx_FrameSize); end
        @(posedge Clk); #1;
        Rst = 1'b1;
        idle(3);
        checks++; if (eofCnt - e0 !== 0 || bytes.size() - b0 !== 0) begin errors++; $display("FAIL midrst_no_eof: got eof=%0d bytes=%0d expected 0 0", eofCnt - e0, bytes.size() - b0); end
        checks++; if (Rx_ValidFrame !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", Rx_ValidFrame); end
    endtask

    initial begin
        test_reset();
        test_basic_frame(1'b0);
        test_stuffed();
        test_misaligned();
        test_short_frame();
        test_abort();
        test_overflow();
        test_basic_frame(1'b1);
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
- Serial front end of the HDLC receive path.
- Takes the raw Rx bit stream and detects opening and closing flags and aborts.
- Removes stuffed zeros, assembles bytes LSB-first and hands them to the Rx buffer/controller stage with per-frame status.
- Produces the Rx_* frame signals consumed downstream: NewByte, ValidFrame, EoF, FrameError, AbortDetect, Overflow, FrameSize.

Parameters:
- MAX_BYTES, 128: maximum data bytes per frame, including FCS; bytes beyond this are not emitted.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- RxEN  in  1  bit-valid strobe: Rx is sampled only on cycles with RxEN=1.
- Rx  in  1  serial HDLC bit stream, LSB-first.
- Rx_Data  out  8  destuffed data byte, valid while Rx_NewByte=1.
- Rx_NewByte  out  1  one-cycle pulse: Rx_Data holds a frame byte.
- Rx_FlagDetect  out  1  one-cycle pulse: 01111110 received.
- Rx_AbortDetect  out  1  one-cycle pulse: 7 consecutive ones received.
- Rx_ValidFrame  out  1  high from opening flag until closing flag or abort.
- Rx_EoF  out  1  one-cycle pulse: frame closed, status outputs valid.
- Rx_FrameError  out  1  one-cycle pulse with Rx_EoF: misaligned or short frame.
- Rx_Overflow  out  1  sticky: frame exceeded MAX_BYTES; cleared at next opening flag.
- Rx_FrameSize  out  8  bytes emitted in current/last frame; valid at Rx_EoF.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0; shift register 0x00; ones counter 0; bit counter 0; pending byte invalid; state HUNT.
- All state advances only on RxEN=1 cycles, except single-cycle pulses, which always clear the following cycle.
- Raw history: hist <= {Rx, hist[7:1]}.
- Flag: hist==8'h7E after the shift.
- Ones counter: increments on Rx=1, saturating at 7; clears on Rx=0.
- Abort: ones counter reaches 7.
- Pulse latency: all detection pulses assert the cycle after the completing bit is sampled (1-cycle registered latency).
- Destuffing: Rx=0 while the ones count is exactly 5 is discarded and does not advance the bit counter. A flag's closing 0 follows 6 ones, so it is never discarded.
- Byte assembly: acc <= {bit, acc[7:1]}; bit counter 0..7.
  - On the 8th destuffed bit, acc moves to the pending byte.
  - If a pending byte already existed, it is emitted first: Rx_Data=pending, Rx_NewByte=1.
  - This one-byte delay keeps flag bits out of the data stream.
- State machine:
  - HUNT: ignore data. Flag -> OPEN: Rx_FlagDetect, Rx_ValidFrame=1, counters cleared, Rx_Overflow cleared, Rx_FrameSize=0.
  - OPEN: flag -> stay in OPEN (back-to-back idle flags, no EoF). First destuffed byte completed -> FRAME.
  - FRAME, on flag (closing):
    - If the bit counter was at 7 before the flag's final bit (aligned), emit the pending byte with Rx_NewByte and raise Rx_EoF in the same cycle.
    - Otherwise, drop the pending byte and raise Rx_EoF together with Rx_FrameError.
    - A frame of fewer than 2 emitted bytes also raises Rx_FrameError.
    - The closing flag then acts as the opening flag of the next frame -> OPEN.
  - Any state, on abort: Rx_AbortDetect pulse. If OPEN or FRAME, Rx_ValidFrame drops, the pending byte is discarded, no EoF is raised -> HUNT.
  - In HUNT, abort produces only the pulse.
- Rx_FrameSize: increments per emitted byte, saturating at MAX_BYTES.
- Overflow: an attempted emission beyond MAX_BYTES is suppressed and sets Rx_Overflow. The frame continues, and Rx_EoF still fires at the closing flag.
- Simultaneous events: flag and byte completion on the same bit means flag wins and the completed acc is discarded. Abort has priority over everything.
- RxEN=0: all state holds; pulses still self-clear.
- Reset mid-frame: immediate return to reset values; no EoF is generated.

Test Plan:
- Flags 0x7E, then bytes 0x12 0x34, then flag -> two Rx_NewByte pulses with Rx_Data 0x12 then 0x34. The second pulse coincides with Rx_EoF, Rx_FrameSize=2, Rx_FrameError=0.
- Flag, then 0x3F sent on the wire as 1,1,1,1,1,0,1,0,0 (stuffed zero), then 0xAA, then flag -> bytes 0x3F and 0xAA, no error.
- Flag, then 0x55, then 11 bits of 0x00 (misaligned), then flag -> Rx_EoF and Rx_FrameError together; no byte with value 0x00 emitted at close.
- Flag, then 0x01, then seven 1s -> Rx_AbortDetect one cycle after the 7th one; Rx_ValidFrame=0; no Rx_EoF; state HUNT (next data ignored until a flag).
- MAX_BYTES=4: flag, 6 bytes, flag -> 4 Rx_NewByte pulses, Rx_Overflow=1, Rx_FrameSize=4, Rx_EoF raised. The next opening flag clears Rx_Overflow.
- RxEN toggling 1/0 every cycle during the first scenario -> identical byte/EoF sequence. Rst=0 asserted mid-byte -> all outputs 0 on the next edge.
